// File: rtl/mux8_arbiter.sv
// Two-requester burst arbiter feeding a registered 8-bit 2:1 mux with a valid/ready output.
// Optional per-grant beat limit is compiled in with `define MUX8_ARB_TIMEOUT_EN.
module mux8_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  input  logic       last_a,
  input  logic       last_b,
  input  logic       out_ready,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       sel,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       busy,
  output logic [1:0] dbg_state_o
);

  // Handshake: a beat moves from the granted requester when req && load, where
  // load = !out_valid || out_ready; out_data/out_valid move downstream on out_valid && out_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT_A = 2'd1, GRANT_B = 2'd2} state_e;

  state_e     state_q, state_d;
  logic       last_srv_q, last_srv_d;   // 0 = A served last, 1 = B served last
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;

  logic load, accept_a, accept_b, accept;
  logic timeout_a, timeout_b;

  assign load     = !out_valid_q || out_ready;
  assign accept_a = (state_q == GRANT_A) && req_a && load;
  assign accept_b = (state_q == GRANT_B) && req_b && load;
  assign accept   = accept_a || accept_b;

`ifdef MUX8_ARB_TIMEOUT_EN
  logic [2:0] beat_cnt_q, beat_cnt_d;

  // Every grant is entered from IDLE, so clearing there restarts the count per grant.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE) beat_cnt_d = 3'd0;
    else if (accept)     beat_cnt_d = beat_cnt_q + 3'd1;
  end

  assign timeout_a = accept_a && (beat_cnt_q == 3'd7) && req_b;
  assign timeout_b = accept_b && (beat_cnt_q == 3'd7) && req_a;

  always_ff @(posedge clk) begin
    if (reset) beat_cnt_q <= 3'd0;
    else       beat_cnt_q <= beat_cnt_d;
  end
`else
  assign timeout_a = 1'b0;
  assign timeout_b = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_srv_d = last_srv_q;
    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || last_srv_q)) state_d = GRANT_A;
        else if (req_b)                      state_d = GRANT_B;
      end
      GRANT_A: begin
        if (accept_a && (last_a || timeout_a)) begin
          state_d    = IDLE;
          last_srv_d = 1'b0;
        end
      end
      GRANT_B: begin
        if (accept_b && (last_b || timeout_b)) begin
          state_d    = IDLE;
          last_srv_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_data_d  = accept_b ? data_b : data_a;
      out_valid_d = 1'b1;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_srv_q  <= 1'b1;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_srv_q  <= last_srv_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt_a       = (state_q == GRANT_A);
  assign gnt_b       = (state_q == GRANT_B);
  assign sel         = gnt_b;
  assign busy        = (state_q != IDLE);
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign dbg_state_o = state_q;

endmodule
